// File: rtl/fwft_ser_pkg.sv
// rtl/fwft_ser_pkg.sv - shared types and sizing helpers for the FWFT word serializer
package fwft_ser_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    function automatic int ser_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Clamped to 1 so a degenerate ratio still elaborates far enough to hit the range checks.
    function automatic int ser_cnt_width(input int in_w, input int out_w);
        return ((in_w / out_w) > 1) ? $clog2(in_w / out_w) : 1;
    endfunction

endpackage

// File: rtl/fwft_word_serializer.sv
// rtl/fwft_word_serializer.sv - pops FWFT FIFO words and streams them out as narrower chunks
module fwft_word_serializer
    import fwft_ser_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy
);

    localparam int RATIO = ser_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = ser_cnt_width(IN_WIDTH, OUT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_chk_div
        $error("fwft_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (RATIO < 2) begin : g_chk_ratio
        $error("fwft_word_serializer: IN_WIDTH/OUT_WIDTH must be at least 2");
    end

    ser_state_t          state, state_nxt;
    logic [IN_WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                xfer;

    // Stream outputs come straight from registers so m_ready never reaches them.
    assign m_valid = (state == SHIFT);
    assign busy    = m_valid;
    assign m_last  = m_valid && (cnt == CNT_LAST);
    assign xfer    = m_valid && m_ready;

    if (MSB_FIRST) begin : g_msb
        assign m_data = sreg[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
        assign m_data = sreg[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        cnt_nxt    = cnt;
        fifo_rd_en = 1'b0;
        // Gated by arst_n so nothing is popped while the block is held in reset.
        if (arst_n && !fifo_empty && ((state == IDLE) || (xfer && m_last))) begin
            fifo_rd_en = 1'b1;
        end
        if (fifo_rd_en) begin
            state_nxt = SHIFT;
            sreg_nxt  = fifo_dout;
            cnt_nxt   = '0;
        end else if (xfer) begin
            if (m_last) begin
                state_nxt = IDLE;
            end else begin
                cnt_nxt  = cnt + 1'b1;
                sreg_nxt = MSB_FIRST ? (sreg << OUT_WIDTH) : (sreg >> OUT_WIDTH);
            end
        end
    end

endmodule

// File: tb/tb_fwft_word_serializer.sv
// tb/tb_fwft_word_serializer.sv - scoreboard bench for fwft_word_serializer
module tb_fwft_word_serializer;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    logic        fe_a, rd_a, mv_a, ml_a, rdy_a, busy_a;
    logic [31:0] dout_a;
    logic [7:0]  md_a;
    logic        fe_b, rd_b, mv_b, ml_b, rdy_b, busy_b;
    logic [31:0] dout_b;
    logic [7:0]  md_b;
    logic        fe_c, rd_c, mv_c, ml_c, rdy_c, busy_c;
    logic [15:0] dout_c;
    logic [3:0]  md_c;

    fwft_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .arst_n(arst_n), .fifo_empty(fe_a), .fifo_dout(dout_a), .fifo_rd_en(rd_a),
        .m_valid(mv_a), .m_data(md_a), .m_last(ml_a), .m_ready(rdy_a), .busy(busy_a));
    fwft_word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .arst_n(arst_n), .fifo_empty(fe_b), .fifo_dout(dout_b), .fifo_rd_en(rd_b),
        .m_valid(mv_b), .m_data(md_b), .m_last(ml_b), .m_ready(rdy_b), .busy(busy_b));
    fwft_word_serializer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .arst_n(arst_n), .fifo_empty(fe_c), .fifo_dout(dout_c), .fifo_rd_en(rd_c),
        .m_valid(mv_c), .m_data(md_c), .m_last(ml_c), .m_ready(rdy_c), .busy(busy_c));

    logic [31:0] fq_a[$], fq_b[$], fq_c[$];
    exp_t        exp_a[$], exp_b[$], exp_c[$];
    int          total = 0;
    int          bad = 0;
    bit          pop_a = 0, pop_b = 0, pop_c = 0;
    int          rd_cnt_a = 0;
    int          base;
    bit          stall_prev = 0;
    logic [7:0]  hold_d = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic miss(input string nm, input logic [31:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %h want no chunk", nm, got);
    endtask

    task automatic upd();
        fe_a   = (fq_a.size() == 0);
        dout_a = fe_a ? 32'h0 : fq_a[0];
        fe_b   = (fq_b.size() == 0);
        dout_b = fe_b ? 32'h0 : fq_b[0];
        fe_c   = (fq_c.size() == 0);
        dout_c = fe_c ? 16'h0 : fq_c[0][15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_a && fq_a.size() > 0) void'(fq_a.pop_front());
        if (pop_b && fq_b.size() > 0) void'(fq_b.pop_front());
        if (pop_c && fq_c.size() > 0) void'(fq_c.pop_front());
        pop_a = 0;
        pop_b = 0;
        pop_c = 0;
        upd();
    endtask

    task automatic ea(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_a.push_back(e);
    endtask

    // Monitor: samples mid-cycle, records pops for the FIFO model and scores chunks.
    always @(negedge clk) begin : mon
        exp_t e;
        pop_a = rd_a;
        pop_b = rd_b;
        pop_c = rd_c;
        if (rd_a) rd_cnt_a++;
        if (fe_a) chk("rd_when_empty_a", {31'b0, rd_a}, 32'd0);
        if (stall_prev) begin
            chk("hold_valid_a", {31'b0, mv_a}, 32'd1);
            chk("hold_data_a", {24'b0, md_a}, {24'b0, hold_d});
        end
        stall_prev = mv_a && !rdy_a;
        hold_d = md_a;
        if (mv_a && rdy_a) begin
            if (exp_a.size() == 0) miss("extra_chunk_a", {24'b0, md_a});
            else begin
                e = exp_a.pop_front();
                chk("chunk_a", {24'b0, md_a}, e.d);
                chk("last_a", {31'b0, ml_a}, {31'b0, e.l});
            end
        end
        if (mv_b && rdy_b) begin
            if (exp_b.size() == 0) miss("extra_chunk_b", {24'b0, md_b});
            else begin
                e = exp_b.pop_front();
                chk("chunk_b", {24'b0, md_b}, e.d);
                chk("last_b", {31'b0, ml_b}, {31'b0, e.l});
            end
        end
        if (mv_c && rdy_c) begin
            if (exp_c.size() == 0) miss("extra_chunk_c", {28'b0, md_c});
            else begin
                e = exp_c.pop_front();
                chk("chunk_c", {28'b0, md_c}, e.d);
                chk("last_c", {31'b0, ml_c}, {31'b0, e.l});
            end
        end
    end

    initial begin
        exp_t e;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        rdy_c = 1'b1;
        upd();
        #2 arst_n = 1'b0;

        // Reset state, with a word already waiting that must not be popped
        fq_a.push_back(32'hA1B2C3D4);
        upd();
        #1;
        chk("rst_rd_en", {31'b0, rd_a}, 32'd0);
        chk("rst_valid", {31'b0, mv_a}, 32'd0);
        chk("rst_last", {31'b0, ml_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        repeat (2) tick();
        chk("rst_rd_en_held", {31'b0, rd_a}, 32'd0);

        // Test 1: single word
        base = rd_cnt_a;
        ea(32'hD4, 1'b0); ea(32'hC3, 1'b0); ea(32'hB2, 1'b0); ea(32'hA1, 1'b1);
        arst_n = 1'b1;
        #1;
        chk("t1_rd_en_idle", {31'b0, rd_a}, 32'd1);
        tick();
        chk("t1_latency_valid", {31'b0, mv_a}, 32'd1);
        chk("t1_busy", {31'b0, busy_a}, 32'd1);
        repeat (4) tick();
        chk("t1_valid_after", {31'b0, mv_a}, 32'd0);
        chk("t1_drained", exp_a.size(), 32'd0);
        chk("t1_pops", rd_cnt_a - base, 32'd1);

        // Test 2: back-to-back words, no bubble
        base = rd_cnt_a;
        fq_a.push_back(32'h03020100);
        fq_a.push_back(32'h07060504);
        for (int i = 0; i < 8; i++) ea(32'(i), (i == 3) || (i == 7));
        upd();
        #1;
        chk("t2_rd_first", {31'b0, rd_a}, 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid_run", {31'b0, mv_a}, 32'd1);
            chk("t2_rd_pos", {31'b0, rd_a}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t2_valid_after", {31'b0, mv_a}, 32'd0);
        chk("t2_drained", exp_a.size(), 32'd0);
        chk("t2_pops", rd_cnt_a - base, 32'd2);

        // Test 3: backpressure 1,0,0 repeating
        base = rd_cnt_a;
        fq_a.push_back(32'hA1B2C3D4);
        ea(32'hD4, 1'b0); ea(32'hC3, 1'b0); ea(32'hB2, 1'b0); ea(32'hA1, 1'b1);
        upd();
        for (int i = 0; i < 16; i++) begin
            rdy_a = (i % 3 == 0);
            tick();
        end
        rdy_a = 1'b1;
        chk("t3_valid_after", {31'b0, mv_a}, 32'd0);
        chk("t3_drained", exp_a.size(), 32'd0);
        chk("t3_pops", rd_cnt_a - base, 32'd1);

        // Test 4: stall on the last chunk with a second word queued
        base = rd_cnt_a;
        fq_a.push_back(32'hA1B2C3D4);
        fq_a.push_back(32'h55667788);
        ea(32'hD4, 1'b0); ea(32'hC3, 1'b0); ea(32'hB2, 1'b0); ea(32'hA1, 1'b1);
        ea(32'h88, 1'b0); ea(32'h77, 1'b0); ea(32'h66, 1'b0); ea(32'h55, 1'b1);
        upd();
        repeat (4) tick();
        rdy_a = 1'b0;
        #1;
        chk("t4_last_shown", {31'b0, ml_a}, 32'd1);
        chk("t4_rd_stall", {31'b0, rd_a}, 32'd0);
        repeat (3) begin
            tick();
            chk("t4_rd_stall", {31'b0, rd_a}, 32'd0);
            chk("t4_data_stall", {24'b0, md_a}, 32'hA1);
        end
        rdy_a = 1'b1;
        #1;
        chk("t4_rd_on_ready", {31'b0, rd_a}, 32'd1);
        repeat (6) tick();
        chk("t4_valid_after", {31'b0, mv_a}, 32'd0);
        chk("t4_drained", exp_a.size(), 32'd0);
        chk("t4_pops", rd_cnt_a - base, 32'd2);

        // Test 5: reset after C3 is accepted
        base = rd_cnt_a;
        fq_a.push_back(32'hA1B2C3D4);
        ea(32'hD4, 1'b0); ea(32'hC3, 1'b0);
        upd();
        repeat (3) tick();
        chk("t5_pre_data", {24'b0, md_a}, 32'hB2);
        arst_n = 1'b0;
        #1;
        chk("t5_valid", {31'b0, mv_a}, 32'd0);
        chk("t5_last", {31'b0, ml_a}, 32'd0);
        chk("t5_busy", {31'b0, busy_a}, 32'd0);
        chk("t5_data", {24'b0, md_a}, 32'd0);
        chk("t5_rd_en", {31'b0, rd_a}, 32'd0);
        repeat (2) tick();
        arst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("t5_idle_valid", {31'b0, mv_a}, 32'd0);
        end
        chk("t5_drained", exp_a.size(), 32'd0);
        chk("t5_pops", rd_cnt_a - base, 32'd1);

        // Test 6: MSB-first, 32/8 and 16/4
        fq_b.push_back(32'hA1B2C3D4);
        fq_c.push_back(32'h00001234);
        e.l = 1'b0;
        e.d = 32'hA1; exp_b.push_back(e);
        e.d = 32'hB2; exp_b.push_back(e);
        e.d = 32'hC3; exp_b.push_back(e);
        e.d = 32'hD4; e.l = 1'b1; exp_b.push_back(e);
        e.l = 1'b0;
        e.d = 32'h1; exp_c.push_back(e);
        e.d = 32'h2; exp_c.push_back(e);
        e.d = 32'h3; exp_c.push_back(e);
        e.d = 32'h4; e.l = 1'b1; exp_c.push_back(e);
        upd();
        repeat (7) tick();
        chk("t6_drained_b", exp_b.size(), 32'd0);
        chk("t6_drained_c", exp_c.size(), 32'd0);
        chk("t6_valid_b", {31'b0, mv_b}, 32'd0);
        chk("t6_valid_c", {31'b0, mv_c}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
